// File: rtl/move_dispatcher.sv
// Move dispatcher: queues encoded moves, validates them and strobes each one to the board updater.
// Latency: push at N -> err at N+2 or enable at N+3, done at N+3+SETTLE_CYCLES.
// Backpressure: mv_ready drops while the move queue is full or while a board clear is in progress.
module move_dispatcher #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             engineColor,
    input  logic             clear_req,
    input  logic             mv_valid,
    output logic             mv_ready,
    input  logic [5:0]       mv_from,
    input  logic [5:0]       mv_to,
    input  logic [5:0]       mv_piece,
    input  logic [5:0]       mv_capt,
    input  logic [2:0]       mv_castle,
    input  logic [4:0]       mv_ep,
    output logic             enable,
    output logic             clear,
    output logic [63:0]      initialPosition,
    output logic [63:0]      movedPosition,
    output logic [5:0]       movingPiece,
    output logic [5:0]       capturedPiece,
    output logic [2:0]       castling,
    output logic [4:0]       enpassant,
    output logic             engineColorOut,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] move_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);

    typedef struct packed {
        logic [5:0] from;
        logic [5:0] to;
        logic [5:0] piece;
        logic [5:0] capt;
        logic [2:0] castle;
        logic [4:0] ep;
    } move_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ISSUE,
        S_SETTLE,
        S_CLEARING
    } state_t;

    state_t           state_q;
    move_t            fifo_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    move_t            work_q;
    logic [1:0]       chk_q;
    logic [SW-1:0]    settle_q;
    logic             enable_q;
    logic             clear_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic [CNT_W-1:0] move_count_q;
    logic [63:0]      init_pos_q;
    logic [63:0]      moved_pos_q;
    logic [5:0]       piece_q;
    logic [5:0]       capt_q;
    logic [2:0]       castle_q;
    logic [4:0]       ep_q;

    logic             fifo_empty;
    logic             fifo_full;
    logic             push_d;
    logic             pop_d;
    move_t            head_d;
    move_t            in_d;
    logic [1:0]       chk_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign mv_ready   = !fifo_full && (state_q != S_CLEARING);
    // A push coinciding with a clear request is discarded along with the flushed queue.
    assign push_d     = mv_valid && mv_ready && !clear_req;
    assign pop_d      = (state_q == S_LOAD) && !clear_req;
    assign head_d     = fifo_q[rd_ptr_q[AW-1:0]];
    assign in_d       = '{from: mv_from, to: mv_to, piece: mv_piece, capt: mv_capt,
                          castle: mv_castle, ep: mv_ep};

    always_comb begin
        chk_d = 2'b00;
        if (head_d.from == head_d.to) begin
            chk_d = 2'b01;
        end else if (!$onehot(head_d.piece) || !$onehot0(head_d.capt) ||
                     !$onehot(head_d.castle) || !$onehot(head_d.ep)) begin
            chk_d = 2'b10;
        end else if (head_d.capt == 6'b100000) begin
            chk_d = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (push_d) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= in_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear_req) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_d) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_d) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            work_q       <= '0;
            chk_q        <= 2'b00;
            settle_q     <= '0;
            enable_q     <= 1'b0;
            clear_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            move_count_q <= '0;
            init_pos_q   <= '0;
            moved_pos_q  <= '0;
            piece_q      <= '0;
            capt_q       <= '0;
            castle_q     <= '0;
            ep_q         <= '0;
        end else if (clear_req) begin
            state_q      <= S_CLEARING;
            clear_q      <= 1'b1;
            enable_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            move_count_q <= '0;
        end else begin
            enable_q <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    work_q  <= head_d;
                    chk_q   <= chk_d;
                    state_q <= S_CHECK;
                    // Rejection is flagged as the move enters CHECK so err lands at push+2.
                    if (chk_d != 2'b00) begin
                        err_q      <= 1'b1;
                        err_code_q <= chk_d;
                    end
                end
                S_CHECK: begin
                    if (chk_q == 2'b00) begin
                        state_q      <= S_ISSUE;
                        enable_q     <= 1'b1;
                        move_count_q <= move_count_q + CNT_W'(1);
                        init_pos_q   <= 64'd1 << work_q.from;
                        moved_pos_q  <= 64'd1 << work_q.to;
                        piece_q      <= work_q.piece;
                        capt_q       <= work_q.capt;
                        castle_q     <= work_q.castle;
                        ep_q         <= work_q.ep;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    state_q  <= S_SETTLE;
                    settle_q <= SW'(1);
                    done_q   <= (SETTLE_LAST == SW'(1));
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        // Chain straight into the next queued move to keep issue spacing at 3+SETTLE.
                        state_q <= fifo_empty ? S_IDLE : S_LOAD;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                        done_q   <= ((settle_q + SW'(1)) == SETTLE_LAST);
                    end
                end
                S_CLEARING: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign enable          = enable_q;
    assign clear           = clear_q;
    assign initialPosition = init_pos_q;
    assign movedPosition   = moved_pos_q;
    assign movingPiece     = piece_q;
    assign capturedPiece   = capt_q;
    assign castling        = castle_q;
    assign enpassant       = ep_q;
    assign engineColorOut  = engineColor;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign err             = err_q;
    assign err_code        = err_code_q;
    assign move_count      = move_count_q;

endmodule

// File: tb/tb_move_dispatcher.sv
// Scoreboard bench for move_dispatcher: directed moves, expected enables/errs queued, checked by a monitor.
module tb_move_dispatcher;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        engineColor;
    logic        clear_req;
    logic        mv_valid;
    logic        mv_ready;
    logic [5:0]  mv_from, mv_to, mv_piece, mv_capt;
    logic [2:0]  mv_castle;
    logic [4:0]  mv_ep;
    logic        enable, clear;
    logic [63:0] initialPosition, movedPosition;
    logic [5:0]  movingPiece, capturedPiece;
    logic [2:0]  castling;
    logic [4:0]  enpassant;
    logic        engineColorOut;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] move_count;

    move_dispatcher #(.DEPTH(4), .SETTLE_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .engineColor(engineColor), .clear_req(clear_req),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to),
        .mv_piece(mv_piece), .mv_capt(mv_capt), .mv_castle(mv_castle), .mv_ep(mv_ep),
        .enable(enable), .clear(clear), .initialPosition(initialPosition),
        .movedPosition(movedPosition), .movingPiece(movingPiece), .capturedPiece(capturedPiece),
        .castling(castling), .enpassant(enpassant), .engineColorOut(engineColorOut),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .move_count(move_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_err;
        logic [1:0]   code;
        logic [159:0] bundle;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   last_done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [159:0] mk_bundle(input logic [63:0] ip, input logic [63:0] mp,
                                               input logic [5:0] pc, input logic [5:0] cp,
                                               input logic [2:0] cs, input logic [4:0] ep);
        return {12'd0, ip, mp, pc, cp, cs, ep};
    endfunction

    // Monitor: every enable or err strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (enable || err) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: enable=%0b err=%0b with nothing expected (cycle %0d)",
                             enable, err, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind", {enable, err}, e.is_err ? 2'b01 : 2'b10);
                    chk("strobe_cycle", cyc, e.cyc);
                    if (e.is_err)
                        chk("err_code", err_code, e.code);
                    else
                        chk("bundle", mk_bundle(initialPosition, movedPosition, movingPiece,
                                                capturedPiece, castling, enpassant), e.bundle);
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic push_mv(input logic [5:0] f, input logic [5:0] t, input logic [5:0] pc,
                           input logic [5:0] cp, input logic [2:0] cs, input logic [4:0] ep,
                           output int pcyc);
        int budget;
        @(negedge clk);
        mv_from = f; mv_to = t; mv_piece = pc; mv_capt = cp; mv_castle = cs; mv_ep = ep;
        mv_valid = 1'b1;
        budget = 0;
        while (!mv_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!mv_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: mv_ready stuck 0 expected 1");
        end
        pcyc = cyc + 1;
        @(posedge clk);
    endtask

    task automatic release_in();
        @(negedge clk);
        mv_valid = 1'b0;
    endtask

    task automatic exp_en(input logic [5:0] f, input logic [5:0] t, input logic [5:0] pc,
                          input logic [5:0] cp, input logic [2:0] cs, input logic [4:0] ep,
                          input int c);
        exp_t e;
        logic [63:0] one;
        one = 64'd1;
        e.is_err = 1'b0;
        e.code   = 2'b00;
        e.bundle = mk_bundle(one << f, one << t, pc, cp, cs, ep);
        e.cyc    = c;
        exp_q.push_back(e);
    endtask

    task automatic exp_err(input logic [1:0] code, input int c);
        exp_t e;
        e.is_err = 1'b1;
        e.code   = code;
        e.bundle = '0;
        e.cyc    = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk);
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0b expected 0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, p0, snap;
        reset_n = 1'b0; engineColor = 1'b0; clear_req = 1'b0; mv_valid = 1'b0;
        mv_from = '0; mv_to = '0; mv_piece = '0; mv_capt = '0; mv_castle = '0; mv_ep = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", mv_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {enable, clear, done, err}, 4'b0000);
        chk("rst_count", move_count, 16'd0);
        chk("rst_errcode", err_code, 2'b00);
        chk("rst_init_pos", initialPosition, 64'd0);
        reset_n = 1'b1;
        engineColor = 1'b1;
        #1 chk("color_pass", engineColorOut, 1'b1);

        // Single pawn move 12 -> 28, hand-computed masks and latency.
        push_mv(6'd12, 6'd28, 6'b000001, 6'b0, 3'b001, 5'b00001, p);
        begin
            exp_t e;
            e.is_err = 1'b0; e.code = 2'b00; e.cyc = p + 3;
            e.bundle = mk_bundle(64'h1000, 64'h1000_0000, 6'b000001, 6'b0, 3'b001, 5'b00001);
            exp_q.push_back(e);
        end
        release_in();
        wait_idle();
        chk("t1_done_latency", last_done_cyc - p, 5);
        chk("t1_count", move_count, 16'd1);

        // Five back-to-back knight moves: queue fills, issues spaced by 3+SETTLE.
        for (int k = 0; k < 5; k++) begin
            push_mv(6'(k + 1), 6'(k + 40), 6'b000100, 6'b0, 3'b001, 5'b00001, p);
            if (k == 0) p0 = p;
            chk("t2_push_cycle", p - p0, k);
            exp_en(6'(k + 1), 6'(k + 40), 6'b000100, 6'b0, 3'b001, 5'b00001, p0 + 3 + 5 * k);
        end
        release_in();
        chk("t2_ready_full", mv_ready, 1'b0);
        wait_idle();
        chk("t2_count", move_count, 16'd6);

        // from == to is rejected; a following legal move still issues.
        push_mv(6'd7, 6'd7, 6'b000001, 6'b0, 3'b001, 5'b00001, p);
        exp_err(2'b01, p + 2);
        release_in();
        wait_idle();
        push_mv(6'd63, 6'd0, 6'b010000, 6'b000010, 3'b001, 5'b00001, p);
        exp_en(6'd63, 6'd0, 6'b010000, 6'b000010, 3'b001, 5'b00001, p + 3);
        release_in();
        wait_idle();
        chk("t3_count", move_count, 16'd7);
        chk("t3_errcode_hold", err_code, 2'b01);

        // Bad one-hot piece, then a king capture.
        push_mv(6'd1, 6'd2, 6'b000011, 6'b0, 3'b001, 5'b00001, p);
        exp_err(2'b10, p + 2);
        release_in();
        wait_idle();
        push_mv(6'd3, 6'd4, 6'b000010, 6'b100000, 3'b001, 5'b00001, p);
        exp_err(2'b11, p + 2);
        release_in();
        wait_idle();
        chk("t4_count", move_count, 16'd7);

        // Clear during SETTLE of the first move with two more queued.
        push_mv(6'd8, 6'd16, 6'b000001, 6'b0, 3'b001, 5'b00001, p0);
        exp_en(6'd8, 6'd16, 6'b000001, 6'b0, 3'b001, 5'b00001, p0 + 3);
        push_mv(6'd9, 6'd17, 6'b000001, 6'b0, 3'b001, 5'b00001, p);
        push_mv(6'd10, 6'd18, 6'b000001, 6'b0, 3'b001, 5'b00001, p);
        release_in();
        wait_cyc(p0 + 4);
        snap = done_cnt;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("t5_clear_pulse", clear, 1'b1);
        chk("t5_count_zero", move_count, 16'd0);
        chk("t5_enable_low", enable, 1'b0);
        @(negedge clk);
        chk("t5_clear_single", clear, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_no_done", done_cnt, snap);
        chk("t5_idle", busy, 1'b0);
        chk("t5_ready", mv_ready, 1'b1);

        // Reset asserted while enable is high.
        push_mv(6'd20, 6'd36, 6'b001000, 6'b0, 3'b100, 5'b00001, p);
        exp_en(6'd20, 6'd36, 6'b001000, 6'b0, 3'b100, 5'b00001, p + 3);
        release_in();
        wait_cyc(p + 3);
        chk("t6_enable_high", enable, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_enable_drop", enable, 1'b0);
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_count_rst", move_count, 16'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_ready_after", mv_ready, 1'b1);
        chk("t6_busy_after", busy, 1'b0);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
